// File: rtl/uart_seq_pkg.sv
//==============================================================================
// Module      : uart_seq_pkg
// Description : Shared types and defaults for the UART frame sequencer.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package uart_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SNAP = 3'd1,
        ADDR = 3'd2,
        LOAD = 3'd3,
        SEND = 3'd4,
        CSUM = 3'd5,
        DONE = 3'd6
    } seq_state_t;

    localparam int unsigned c_n_bytes_default = 56;
    localparam int unsigned c_period_default  = 50000;

    // Low address bits are inverted so each 32-bit word goes out MSB first.
    localparam logic [1:0]  c_swap_mask       = 2'b11;

endpackage

`default_nettype wire

// File: rtl/frame_tick_gen.sv
//==============================================================================
// Module      : frame_tick_gen
// Description : Free-running modulo-PERIOD counter; tick is high on the last count.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module frame_tick_gen
    import uart_seq_pkg::*;
#(
    parameter int PERIOD = int'(c_period_default),
    parameter int CNT_W  = 17
) (
    input  logic CLK_MUXOUT,
    input  logic RST_B,
    output logic tick
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == c_last_cnt);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge CLK_MUXOUT or negedge RST_B) begin
        if (!RST_B) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_frame_sequencer.sv
//==============================================================================
// Module      : uart_frame_sequencer
// Description : Periodically snapshots the register bank and streams it to the
//               UART TX over valid/ready. FRAME_CHECKSUM_EN appends an XOR byte.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module uart_frame_sequencer
    import uart_seq_pkg::*;
#(
    parameter int N_BYTES = int'(c_n_bytes_default),
    parameter int PERIOD  = int'(c_period_default),
    parameter int CNT_W   = 17,
    parameter int AW      = 6
) (
    input  logic          CLK_MUXOUT,
    input  logic          RST_B,
    input  logic          start,
    input  logic          ovr_clr,
    output logic          snap,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun
);

    localparam logic [AW-1:0] c_last_idx = AW'(N_BYTES - 1);

    logic tick;

    frame_tick_gen #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_tick (
        .CLK_MUXOUT (CLK_MUXOUT),
        .RST_B      (RST_B),
        .tick       (tick)
    );

    seq_state_t    state_q,      state_d;
    logic [AW-1:0] idx_q,        idx_d;
    logic          snap_q,       snap_d;
    logic [7:0]    tx_data_q,    tx_data_d;
    logic          tx_valid_q,   tx_valid_d;
    logic          busy_q,       busy_d;
    logic          frame_done_q, frame_done_d;
    logic          overrun_q,    overrun_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]    csum_q,       csum_d;
`endif

    logic accept;
    assign accept = tx_valid_q && tx_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = 1'b0;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        frame_done_d = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (tick && start) begin
                    state_d = SNAP;
                    snap_d  = 1'b1;
                end
            end
            SNAP: begin
                idx_d   = '0;
                state_d = ADDR;
`ifdef FRAME_CHECKSUM_EN
                csum_d  = '0;
`endif
            end
            ADDR: state_d = LOAD;
            LOAD: begin
                tx_data_d  = rd_data;
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                if (accept) begin
`ifdef FRAME_CHECKSUM_EN
                    csum_d = csum_q ^ tx_data_q;
`endif
                    if (idx_q == c_last_idx) begin
`ifdef FRAME_CHECKSUM_EN
                        // Checksum goes out back-to-back, so valid stays high.
                        tx_data_d    = csum_q ^ tx_data_q;
                        state_d      = CSUM;
`else
                        tx_valid_d   = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = DONE;
`endif
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        tx_valid_d = 1'b0;
                        state_d    = ADDR;
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    tx_valid_d   = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        // A late tick wins over a simultaneous clear so no overrun is lost.
        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge CLK_MUXOUT or negedge RST_B) begin
        if (!RST_B) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            snap_q       <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign rd_addr    = {idx_q[AW-1:2], idx_q[1:0] ^ c_swap_mask};
    assign snap       = snap_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_sequencer.sv
//==============================================================================
// Module      : tb_uart_frame_sequencer
// Description : Scoreboard bench for uart_frame_sequencer (PERIOD=16, N_BYTES=8).
// Revision    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_frame_sequencer;

    localparam int PERIOD  = 16;
    localparam int N_BYTES = 8;
    localparam int CNT_W   = 4;
    localparam int AW      = 3;
`ifdef FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = N_BYTES + 1;
`else
    localparam int FRAME_LEN = N_BYTES;
`endif

    logic          clk;
    logic          rst_b;
    logic          start;
    logic          ovr_clr;
    logic          tx_ready;
    logic          snap;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          busy;
    logic          frame_done;
    logic          overrun;

    uart_frame_sequencer #(
        .N_BYTES (N_BYTES),
        .PERIOD  (PERIOD),
        .CNT_W   (CNT_W),
        .AW      (AW)
    ) dut (
        .CLK_MUXOUT (clk),
        .RST_B      (rst_b),
        .start      (start),
        .ovr_clr    (ovr_clr),
        .snap       (snap),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model: registered read, contents = address + 1.
    always @(posedge clk) rd_data <= 8'(rd_addr) + 8'd1;

    // Reference tick phase: value the DUT's period counter should hold.
    logic [3:0] ref_cnt;
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) ref_cnt <= 4'd0;
        else        ref_cnt <= (ref_cnt == 4'(PERIOD - 1)) ? 4'd0 : ref_cnt + 4'd1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        return 8'((i ^ 3) + 1);
    endfunction

    logic [7:0] exp_q[$];

    task automatic push_frame();
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < N_BYTES; i++) begin
            exp_q.push_back(exp_byte(i));
            x = x ^ exp_byte(i);
        end
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Monitor state, updated on the falling edge.
    int cyc = 0, byte_cnt = 0, snaps = 0, offers = 0, dones = 0;
    int snap_cyc = 0, last_acc_cyc = 0;
    bit first_off_pending = 0, busy_chk_pending = 0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_b) begin
            byte_cnt          = 0;
            first_off_pending = 0;
            busy_chk_pending  = 0;
        end else begin
            cyc++;
            if (busy_chk_pending) begin
                check_eq("busy_after_done", 32'(busy), 32'd0);
                busy_chk_pending = 0;
            end
            if (snap) begin
                snaps++;
                snap_cyc          = cyc;
                first_off_pending = 1;
                check_eq("snap_after_tick", 32'(ref_cnt), 32'd0);
            end
            if (tx_valid) begin
                offers++;
                if (first_off_pending) begin
                    check_eq("first_valid_latency", 32'(cyc - snap_cyc), 32'd3);
                    first_off_pending = 0;
                end
            end
            if (tx_valid && tx_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
                check_eq("tx_byte", 32'(tx_data), 32'(e));
                byte_cnt++;
                last_acc_cyc = cyc;
            end
            if (frame_done) begin
                check_eq("bytes_per_frame", 32'(byte_cnt), 32'(FRAME_LEN));
                check_eq("done_latency", 32'(cyc - last_acc_cyc), 32'd1);
                byte_cnt = 0;
                dones++;
                busy_chk_pending = 1;
            end
        end
    end

    task automatic wait_snap(output int waited);
        int s0;
        s0     = snaps;
        waited = 0;
        while (snaps == s0 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check_eq("snap_seen", 32'(snaps - s0), 32'd1);
    endtask

    // One frame; optionally hold tx_ready low for stall_len cycles on byte stall_byte (>=1).
    task automatic run_frame(input int stall_byte, input int stall_len);
        int d0, n;
        push_frame();
        d0    = dones;
        start = 1'b1;
        wait_snap(n);
        check_eq("snap_within_period", 32'(n <= PERIOD + 1), 32'd1);
        start = 1'b0;
        if (stall_len > 0) begin
            n = 0;
            while (byte_cnt < stall_byte && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            tx_ready = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!tx_valid && n < 10);
            for (int k = 0; k < stall_len; k++) begin
                check_eq("stall_valid", 32'(tx_valid), 32'd1);
                check_eq("stall_data", 32'(tx_data), 32'(exp_byte(stall_byte)));
                @(negedge clk);
            end
            @(posedge clk); #1;
            tx_ready = 1'b1;
        end
        n = 0;
        while (dones == d0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("frame_done_seen", 32'(dones - d0), 32'd1);
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_ovr_clr();
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
    endtask

    initial begin
        int s0, o0, n;
        rst_b    = 1'b0;
        start    = 1'b0;
        ovr_clr  = 1'b0;
        tx_ready = 1'b1;
        #12;
        check_eq("rst_snap",       32'(snap),       32'd0);
        check_eq("rst_tx_valid",   32'(tx_valid),   32'd0);
        check_eq("rst_tx_data",    32'(tx_data),    32'd0);
        check_eq("rst_busy",       32'(busy),       32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_overrun",    32'(overrun),    32'd0);
        check_eq("rst_rd_addr",    32'(rd_addr),    32'd3);
        @(posedge clk); #2;
        rst_b = 1'b1;

        // Plain frame; it outlasts PERIOD, so the mid-frame tick must flag overrun.
        run_frame(0, 0);
        check_eq("overrun_long_frame", 32'(overrun), 32'd1);
        pulse_ovr_clr();
        check_eq("overrun_cleared_1", 32'(overrun), 32'd0);

        // Short backpressure on the second byte.
        run_frame(1, 5);

        // Long backpressure so a tick lands mid-frame.
        pulse_ovr_clr();
        run_frame(1, 20);
        check_eq("overrun_stall", 32'(overrun), 32'd1);
        pulse_ovr_clr();
        check_eq("overrun_cleared_2", 32'(overrun), 32'd0);

        // Idle with start low across three ticks.
        s0 = snaps;
        o0 = offers;
        repeat (3 * PERIOD) @(posedge clk);
        #1;
        check_eq("idle_no_snap",    32'(snaps - s0),  32'd0);
        check_eq("idle_no_valid",   32'(offers - o0), 32'd0);
        check_eq("idle_no_overrun", 32'(overrun),     32'd0);
        run_frame(0, 0);

        // Reset while byte 5 is being offered.
        pulse_ovr_clr();
        push_frame();
        start = 1'b1;
        wait_snap(n);
        start = 1'b0;
        n = 0;
        while (byte_cnt < 4 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < 10);
        check_eq("byte5_offered", 32'(tx_data), 32'(exp_byte(4)));
        #2 rst_b = 1'b0;
        #1;
        check_eq("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_mid_busy",     32'(busy),     32'd0);
        check_eq("rst_mid_rd_addr",  32'(rd_addr),  32'd3);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 rst_b = 1'b1;
        run_frame(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
